// File: rtl/dff_gate_enable_ctrl.sv
// Enable generator for a clock-gated D flip-flop: watches d_in for activity, gates
// after a programmable quiet run, and counts the edges spent gated.
module dff_gate_enable_ctrl #(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned IDLE_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_in,
  input  logic             force_on,
  input  logic             clr_cnt,
  output logic             enable,
  output logic             wake,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] gated_cnt
);

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_HOLDOFF = 2'd1,
    ST_GATED   = 2'd2
  } state_t;

  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state, state_n;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;
  logic              d_prev;
  logic              wake_n;
  logic              act;

  assign act     = d_in ^ d_prev;
  assign state_o = state;

  // Next-state: force_on has priority over data activity.
  always_comb begin
    state_n    = state;
    idle_cnt_n = idle_cnt;
    wake_n     = 1'b0;
    if (force_on) begin
      state_n    = ST_ACTIVE;
      idle_cnt_n = '0;
      wake_n     = (state == ST_GATED);
    end else begin
      case (state)
        ST_ACTIVE: begin
          if (act) begin
            idle_cnt_n = '0;
          end else if (IDLE_CYCLES == 1) begin
            state_n = ST_GATED;
          end else begin
            state_n    = ST_HOLDOFF;
            idle_cnt_n = IDLE_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (act) begin
            state_n    = ST_ACTIVE;
            idle_cnt_n = '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state_n    = ST_GATED;
            idle_cnt_n = '0;
          end else begin
            idle_cnt_n = idle_cnt + IDLE_W'(1);
          end
        end
        ST_GATED: begin
          if (act) begin
            state_n = ST_ACTIVE;
            wake_n  = 1'b1;
          end
        end
        default: begin
          state_n    = ST_ACTIVE;
          idle_cnt_n = '0;
        end
      endcase
    end
  end

  // Registered state, outputs and the saturating gated-edge counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_ACTIVE;
      idle_cnt  <= '0;
      d_prev    <= 1'b0;
      enable    <= 1'b1;
      wake      <= 1'b0;
      gated_cnt <= '0;
    end else begin
      state    <= state_n;
      idle_cnt <= idle_cnt_n;
      d_prev   <= d_in;
      enable   <= (state_n != ST_GATED);
      wake     <= wake_n;
      if (clr_cnt) begin
        gated_cnt <= '0;
      end else if ((state == ST_GATED) && (gated_cnt != CNT_MAX)) begin
        gated_cnt <= gated_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dff_gate_enable_ctrl.sv
// Bench for dff_gate_enable_ctrl: three parameterisations driven in parallel, checked
// against a quiet-run-length model, a directed vector table and corner sequences.
module tb_dff_gate_enable_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic d_in = 1'b0;
  logic force_on = 1'b0;
  logic clr_cnt = 1'b0;

  logic        en0, wk0, en1, wk1, en2, wk2;
  logic [1:0]  st0, st1, st2;
  logic [15:0] cnt0, cnt2;
  logic [2:0]  cnt1;

  always #5 clk = ~clk;

  dff_gate_enable_ctrl #(.IDLE_CYCLES(4), .CNT_W(16), .IDLE_W(8)) u_dut (
    .clk(clk), .rst(rst), .d_in(d_in), .force_on(force_on), .clr_cnt(clr_cnt),
    .enable(en0), .wake(wk0), .state_o(st0), .gated_cnt(cnt0));

  dff_gate_enable_ctrl #(.IDLE_CYCLES(4), .CNT_W(3), .IDLE_W(8)) u_sat (
    .clk(clk), .rst(rst), .d_in(d_in), .force_on(force_on), .clr_cnt(clr_cnt),
    .enable(en1), .wake(wk1), .state_o(st1), .gated_cnt(cnt1));

  dff_gate_enable_ctrl #(.IDLE_CYCLES(1), .CNT_W(16), .IDLE_W(8)) u_one (
    .clk(clk), .rst(rst), .d_in(d_in), .force_on(force_on), .clr_cnt(clr_cnt),
    .enable(en2), .wake(wk2), .state_o(st2), .gated_cnt(cnt2));

  int n_vec = 0;
  int n_err = 0;

  // Model: q = length of the current quiet run (0 after activity/force/reset),
  // capped at the idle threshold; gated exactly when q reached the threshold.
  int idle_p[3] = '{4, 4, 1};
  int max_p[3]  = '{65535, 7, 65535};
  int q[3];
  int mcnt[3];
  int mwake[3];
  logic m_dprev = 1'b0;

  typedef struct {
    logic r, d, f, c;
    int   st;
    logic en, wk;
    int   cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic d, logic f, logic c,
                              int st, logic en, logic wk, int cnt);
    vec_t v;
    v.r = r; v.d = d; v.f = f; v.c = c;
    v.st = st; v.en = en; v.wk = wk; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(string name, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(logic r, logic d, logic f, logic c);
    logic act;
    int   was_g;
    act = d ^ m_dprev;
    for (int i = 0; i < 3; i++) begin
      if (!r) begin
        q[i] = 0; mcnt[i] = 0; mwake[i] = 0;
      end else begin
        was_g = (q[i] >= idle_p[i]) ? 1 : 0;
        if (c) mcnt[i] = 0;
        else if (was_g != 0 && mcnt[i] < max_p[i]) mcnt[i]++;
        if (f || act) q[i] = 0;
        else if (q[i] < idle_p[i]) q[i]++;
        mwake[i] = (was_g != 0 && (f || act)) ? 1 : 0;
      end
    end
    m_dprev = r ? d : 1'b0;
  endtask

  task automatic check_model();
    int st, en, wk, cnt, exp_st;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin st = int'(st0); en = int'(en0); wk = int'(wk0); cnt = int'(cnt0); end
        1: begin st = int'(st1); en = int'(en1); wk = int'(wk1); cnt = int'(cnt1); end
        default: begin st = int'(st2); en = int'(en2); wk = int'(wk2); cnt = int'(cnt2); end
      endcase
      exp_st = (q[i] == 0) ? 0 : (q[i] < idle_p[i]) ? 1 : 2;
      check($sformatf("model%0d_state", i), st, exp_st);
      check($sformatf("model%0d_enable", i), en, (q[i] < idle_p[i]) ? 1 : 0);
      check($sformatf("model%0d_wake", i), wk, mwake[i]);
      check($sformatf("model%0d_cnt", i), cnt, mcnt[i]);
    end
  endtask

  // One clock: drive on the falling edge, advance the model at the rising edge, check 1ns later.
  task automatic step(logic r, logic d, logic f, logic c);
    @(negedge clk);
    rst = r; d_in = d; force_on = f; clr_cnt = c;
    @(posedge clk);
    model_step(r, d, f, c);
    #1;
    check_model();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin q[i] = 0; mcnt[i] = 0; mwake[i] = 0; end

    // Directed table against the IDLE_CYCLES=4, CNT_W=16 instance.
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 3));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 4));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 4));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 4));
    tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 4));
    tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 5));
    tbl.push_back(mk(1, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 1, 2));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 2));

    foreach (tbl[k]) begin
      step(tbl[k].r, tbl[k].d, tbl[k].f, tbl[k].c);
      check($sformatf("tbl%0d_state", k), int'(st0), tbl[k].st);
      check($sformatf("tbl%0d_enable", k), int'(en0), int'(tbl[k].en));
      check($sformatf("tbl%0d_wake", k), int'(wk0), int'(tbl[k].wk));
      check($sformatf("tbl%0d_cnt", k), int'(cnt0), tbl[k].cnt);
    end

    // force_on held for 20 quiet edges in total keeps the gate open.
    for (int k = 0; k < 18; k++) begin
      step(1, 0, 1, 0);
      check("force_hold_enable", int'(en0), 1);
    end
    // After force drops, three HOLDOFF edges then GATED on the fourth.
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 0);
      check("force_release_state", int'(st0), (k < 3) ? 1 : 2);
    end
    step(1, 0, 0, 0);
    // Reset from GATED: ACTIVE, enable high, no wake, counter cleared.
    step(0, 0, 0, 0);
    check("rst_gated_state", int'(st0), 0);
    check("rst_gated_enable", int'(en0), 1);
    check("rst_gated_wake", int'(wk0), 0);
    check("rst_gated_cnt", int'(cnt0), 0);

    // Saturation on the 3-bit counter: gate at edge 4, then 12 gated edges.
    step(1, 0, 0, 0);
    for (int k = 2; k <= 16; k++) begin
      step(1, 0, 0, 0);
      if (k >= 12) check("sat_cnt", int'(cnt1), 7);
    end
    step(0, 0, 0, 0);
    check("sat_rst_cnt", int'(cnt1), 0);
    check("sat_rst_state", int'(st1), 0);

    // IDLE_CYCLES=1 with d_in toggling every other edge.
    for (int p = 0; p < 8; p++) begin
      logic dv;
      dv = (p % 2 == 0) ? 1'b1 : 1'b0;
      step(1, dv, 0, 0);
      check("one_act_enable", int'(en2), 1);
      check("one_act_wake", int'(wk2), (p == 0) ? 0 : 1);
      step(1, dv, 0, 0);
      check("one_quiet_enable", int'(en2), 0);
      check("one_quiet_wake", int'(wk2), 0);
    end

    // Randomised traffic with long quiet runs, checked only against the model.
    for (int k = 0; k < 400; k++) begin
      logic r, d, f, c;
      r = ($urandom_range(0, 39) != 0);
      d = ($urandom_range(0, 5) == 0) ? ~d_in : d_in;
      f = ($urandom_range(0, 11) == 0);
      c = ($urandom_range(0, 15) == 0);
      step(r, d, f, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
